btle_link_sequencer: RTL
========================

Name: btle_link_sequencer

Overview:
- Command-driven controller that sequences the BTLE PHY through one radio event: load channel/CRC config, start TX, wait inter-frame space (IFS), open an RX window and collect decode results.
- Supports TX-only, RX-only, TX-then-RX and RX-then-TX events.
- Sits between the host/link-layer register bank and the PHY's control strobes, and gates the PHY's RX sample-valid input.

Parameters:
- CHANNEL_NUMBER_BIT_WIDTH, 6, width of channel index.
- CRC_STATE_BIT_WIDTH, 24, width of CRC init state.
- IFS_CYCLES, 1200, clk cycles of inter-frame space (150 us at 8 MHz).
- TIMEOUT_BIT_WIDTH, 16, width of RX window timeout counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_mode  in  2  00 TX, 01 RX, 10 TX->RX, 11 RX->TX.
- cmd_channel  in  CHANNEL_NUMBER_BIT_WIDTH  channel for the event.
- cmd_crc_init  in  CRC_STATE_BIT_WIDTH  CRC init for TX and RX.
- cmd_rx_timeout  in  TIMEOUT_BIT_WIDTH  RX listen window in cycles; 0 = unlimited.
- abort  in  1  level; terminate event.
- phy_tx_channel_number  out  CHANNEL_NUMBER_BIT_WIDTH  registered cmd_channel.
- phy_tx_channel_number_load  out  1  1-cycle pulse.
- phy_tx_crc_state_init_bit  out  CRC_STATE_BIT_WIDTH  registered cmd_crc_init.
- phy_tx_crc_state_init_bit_load  out  1  1-cycle pulse.
- phy_tx_start  out  1  1-cycle pulse.
- phy_tx_done  in  1  PHY last-TX-sample strobe.
- phy_rx_channel_number  out  CHANNEL_NUMBER_BIT_WIDTH  registered cmd_channel.
- phy_rx_crc_state_init_bit  out  CRC_STATE_BIT_WIDTH  registered cmd_crc_init.
- phy_rx_en  out  1  AND-gate for the PHY's rx_iq_valid.
- phy_rx_hit_flag  in  1  access address found.
- phy_rx_decode_end  in  1  packet decode finished.
- phy_rx_crc_ok  in  1  valid at decode_end.
- phy_rx_payload_length  in  7  valid at decode_end.
- busy  out  1  not IDLE.
- done  out  1  1-cycle pulse at event end.
- status  out  2  00 ok, 01 RX timeout, 10 CRC fail, 11 aborted.
- rx_length  out  7  captured payload length.

Behaviour:
Reset (rst=0, async):
- State IDLE; cmd_ready=1.
- All pulses, busy, done, phy_rx_en = 0.
- status=00, rx_length=0, channel/crc registers=0.

States:
- IDLE
  - cmd_valid&cmd_ready: register mode/channel/crc/timeout -> LOAD.
  - cmd_valid ignored when not IDLE.
- LOAD (1 cycle)
  - Assert both load pulses.
  - TX-first modes -> START_TX; RX-first modes -> RX_LISTEN.
- START_TX (1 cycle): phy_tx_start=1 -> TX_WAIT.
- TX_WAIT
  - Wait phy_tx_done.
  - Mode TX, or second leg of RX->TX: -> DONE, status 00.
  - Mode TX->RX: -> IFS.
- IFS
  - Counter loaded with IFS_CYCLES-1, counts to 0, then exits (exactly IFS_CYCLES cycles in IFS).
  - Exit to RX_LISTEN for TX->RX, or START_TX for RX->TX.
  - phy_rx_en=0 throughout.
- RX_LISTEN
  - phy_rx_en=1; timeout counter decrements each cycle from cmd_rx_timeout.
  - phy_rx_hit_flag -> RX_DECODE.
  - Counter reaches 0 (non-zero timeout) -> DONE, status 01.
  - Hit and expiry in the same cycle: hit wins.
- RX_DECODE
  - phy_rx_en=1, no timeout.
  - phy_rx_decode_end: capture rx_length.
  - crc_ok=0 -> DONE, status 10.
  - crc_ok=1: RX->TX -> IFS; otherwise -> DONE, status 00.
- DONE (1 cycle)
  - done=1 -> IDLE.
  - status/rx_length hold until the next command is accepted; cleared to 0 on accept.

Abort:
- In LOAD/START_TX/IFS/RX_LISTEN/RX_DECODE: -> DONE next cycle, status 11, phy_rx_en drops same edge.
- In TX_WAIT: deferred until phy_tx_done, then DONE with status 11; no packet is cut mid-air.
- In START_TX: tx_start still pulses this cycle; the deferral then applies in TX_WAIT.
- Asserted in IDLE: no effect.
- Asserted together with cmd_valid in IDLE: command accepted, abort applies in LOAD.

Latency:
- Accept -> tx_start is 2 cycles.
- phy_tx_done -> phy_rx_en=1 is IFS_CYCLES+1 cycles.
- Reset mid-event: immediate return to IDLE; any in-flight PHY TX is the PHY's concern.

Optional Feature:
Macro BTLE_SEQ_AUTO_RETRY_EN.
- Defined:
  - Extra parameter MAX_RETRY (default 3).
  - Extra output retry_count (2 bits).
  - In TX->RX mode, status 01 or 10 restarts at START_TX (no reload) after IFS_CYCLES idle, up to MAX_RETRY times.
  - Final status is the last attempt's; retry_count = retries performed.
  - Abort never retries.
- Undefined: no retry, no retry_count port, single attempt.

Test Plan:
- Mode 00, channel 37, crc 0x555555, tx_done 100 cycles after start -> load pulses at accept+1, tx_start at accept+2, done at tx_done+1, status 00.
- Mode 10, IFS_CYCLES=1200, hit 50 cycles into window, decode_end with crc_ok=1, len=12 -> phy_rx_en rises exactly 1201 cycles after tx_done; status 00, rx_length 12.
- Mode 01, timeout 500, no hit -> phy_rx_en high exactly 500 cycles, status 01; repeat with hit on the expiry cycle -> RX_DECODE entered.
- Mode 11, decode_end crc_ok=0 -> no tx_start, status 10; crc_ok=1 -> tx_start 1201 cycles after decode_end.
- Abort during TX_WAIT -> done only at tx_done+1, status 11; abort in RX_LISTEN -> done next cycle, phy_rx_en low.
- With BTLE_SEQ_AUTO_RETRY_EN, MAX_RETRY=3, never hit -> 4 tx_start pulses, retry_count 3, status 01.

Source files
------------

// File: rtl/btle_link_sequencer.sv
// BTLE link sequencer: steps the PHY through one radio event (load, TX, IFS, RX window, decode).
// Optional auto-retry of failed TX->RX events is enabled by defining BTLE_SEQ_AUTO_RETRY_EN.
module btle_link_sequencer #(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int IFS_CYCLES               = 1200,
    parameter int TIMEOUT_BIT_WIDTH        = 16
`ifdef BTLE_SEQ_AUTO_RETRY_EN
    ,
    parameter int MAX_RETRY                = 3
`endif
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [1:0]                          cmd_mode,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] cmd_channel,
    input  logic [CRC_STATE_BIT_WIDTH-1:0]      cmd_crc_init,
    input  logic [TIMEOUT_BIT_WIDTH-1:0]        cmd_rx_timeout,
    input  logic                                abort,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] phy_tx_channel_number,
    output logic                                phy_tx_channel_number_load,
    output logic [CRC_STATE_BIT_WIDTH-1:0]      phy_tx_crc_state_init_bit,
    output logic                                phy_tx_crc_state_init_bit_load,
    output logic                                phy_tx_start,
    input  logic                                phy_tx_done,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] phy_rx_channel_number,
    output logic [CRC_STATE_BIT_WIDTH-1:0]      phy_rx_crc_state_init_bit,
    output logic                                phy_rx_en,
    input  logic                                phy_rx_hit_flag,
    input  logic                                phy_rx_decode_end,
    input  logic                                phy_rx_crc_ok,
    input  logic [6:0]                          phy_rx_payload_length,
    output logic                                busy,
    output logic                                done,
    output logic [1:0]                          status,
    output logic [6:0]                          rx_length
`ifdef BTLE_SEQ_AUTO_RETRY_EN
    ,
    output logic [1:0]                          retry_count
`endif
);

    localparam int IFS_W = (IFS_CYCLES > 2) ? $clog2(IFS_CYCLES) : 1;

    localparam logic [1:0] M_TX   = 2'b00;
    localparam logic [1:0] M_RX   = 2'b01;
    localparam logic [1:0] M_TXRX = 2'b10;
    localparam logic [1:0] M_RXTX = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_CRC     = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START_TX, S_TX_WAIT, S_IFS, S_RX_LISTEN, S_RX_DECODE, S_DONE
    } state_t;

    state_t                                state, state_nxt;
    logic [1:0]                            mode_r;
    logic [CHANNEL_NUMBER_BIT_WIDTH-1:0]   channel_r;
    logic [CRC_STATE_BIT_WIDTH-1:0]        crc_r;
    logic [TIMEOUT_BIT_WIDTH-1:0]          timeout_r;
    logic [TIMEOUT_BIT_WIDTH-1:0]          to_cnt;
    logic [IFS_W-1:0]                      ifs_cnt;
    logic                                  abort_pend;
    logic                                  retrying;
    logic                                  retry_ok;
    logic                                  retry_go;
    logic [1:0]                            end_status;

`ifdef BTLE_SEQ_AUTO_RETRY_EN
    assign retry_ok = (mode_r == M_TXRX) && (int'(retry_count) < MAX_RETRY);
`else
    assign retry_ok = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; end_status is the code latched when DONE is entered
    always_comb begin
        state_nxt  = state;
        end_status = ST_OK;
        retry_go   = 1'b0;
        case (state)
            S_IDLE: if (cmd_valid) state_nxt = S_LOAD;
            S_LOAD: begin
                if (abort) begin
                    state_nxt  = S_DONE;
                    end_status = ST_ABORT;
                end else if (mode_r == M_TX || mode_r == M_TXRX) begin
                    state_nxt = S_START_TX;
                end else begin
                    state_nxt = S_RX_LISTEN;
                end
            end
            // abort here is remembered and honoured only once the packet is out
            S_START_TX: state_nxt = S_TX_WAIT;
            S_TX_WAIT: begin
                if (phy_tx_done) begin
                    if (abort_pend || abort) begin
                        state_nxt  = S_DONE;
                        end_status = ST_ABORT;
                    end else if (mode_r == M_TXRX) begin
                        state_nxt = S_IFS;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_IFS: begin
                if (abort) begin
                    state_nxt  = S_DONE;
                    end_status = ST_ABORT;
                end else if (ifs_cnt == '0) begin
                    state_nxt = (mode_r == M_RXTX || retrying) ? S_START_TX : S_RX_LISTEN;
                end
            end
            S_RX_LISTEN: begin
                if (abort) begin
                    state_nxt  = S_DONE;
                    end_status = ST_ABORT;
                end else if (phy_rx_hit_flag) begin
                    state_nxt = S_RX_DECODE;
                end else if (timeout_r != '0 && to_cnt == TIMEOUT_BIT_WIDTH'(1)) begin
                    if (retry_ok) begin
                        state_nxt = S_IFS;
                        retry_go  = 1'b1;
                    end else begin
                        state_nxt  = S_DONE;
                        end_status = ST_TIMEOUT;
                    end
                end
            end
            S_RX_DECODE: begin
                if (abort) begin
                    state_nxt  = S_DONE;
                    end_status = ST_ABORT;
                end else if (phy_rx_decode_end) begin
                    if (!phy_rx_crc_ok) begin
                        if (retry_ok) begin
                            state_nxt = S_IFS;
                            retry_go  = 1'b1;
                        end else begin
                            state_nxt  = S_DONE;
                            end_status = ST_CRC;
                        end
                    end else if (mode_r == M_RXTX) begin
                        state_nxt = S_IFS;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        cmd_ready                      = (state == S_IDLE);
        busy                           = (state != S_IDLE);
        phy_tx_channel_number_load     = (state == S_LOAD);
        phy_tx_crc_state_init_bit_load = (state == S_LOAD);
        phy_tx_start                   = (state == S_START_TX);
        phy_rx_en                      = (state == S_RX_LISTEN) || (state == S_RX_DECODE);
        done                           = (state == S_DONE);
    end

    assign phy_tx_channel_number     = channel_r;
    assign phy_rx_channel_number     = channel_r;
    assign phy_tx_crc_state_init_bit = crc_r;
    assign phy_rx_crc_state_init_bit = crc_r;

    // Counters reload whenever their state is not active, so every entry starts fresh
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r     <= M_TX;
            channel_r  <= '0;
            crc_r      <= '0;
            timeout_r  <= '0;
            to_cnt     <= '0;
            ifs_cnt    <= '0;
            abort_pend <= 1'b0;
            retrying   <= 1'b0;
            status     <= ST_OK;
            rx_length  <= '0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                mode_r    <= cmd_mode;
                channel_r <= cmd_channel;
                crc_r     <= cmd_crc_init;
                timeout_r <= cmd_rx_timeout;
                status    <= ST_OK;
                rx_length <= '0;
            end
            ifs_cnt <= (state == S_IFS) ? ifs_cnt - 1'b1 : IFS_W'(IFS_CYCLES - 1);
            to_cnt  <= (state == S_RX_LISTEN) ? to_cnt - 1'b1 : timeout_r;
            if (state == S_IDLE)
                abort_pend <= 1'b0;
            else if ((state == S_START_TX || state == S_TX_WAIT) && abort)
                abort_pend <= 1'b1;
            if (retry_go)
                retrying <= 1'b1;
            else if (state == S_START_TX || state == S_IDLE)
                retrying <= 1'b0;
            if (state == S_RX_DECODE && phy_rx_decode_end && !abort)
                rx_length <= phy_rx_payload_length;
            if (state_nxt == S_DONE && state != S_DONE)
                status <= end_status;
        end
    end

`ifdef BTLE_SEQ_AUTO_RETRY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          retry_count <= 2'd0;
        else if (state == S_IDLE && cmd_valid) retry_count <= 2'd0;
        else if (retry_go)                 retry_count <= retry_count + 2'd1;
    end
`endif

endmodule
